// File: rtl/sdram_arbit.sv
// sdram_arbit: passes init commands through, then arbitrates refresh > write > read
// onto the SDRAM command, address and tri-state data pins.
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);
    typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;
    state_t state_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else begin
            case (state_q)
                IDLE:    if (init_end) state_q <= ARBIT;
                ARBIT:   state_q <= aref_req ? AREF : wr_req ? WRITE : rd_req ? READ : ARBIT;
                AREF:    if (aref_end) state_q <= ARBIT;
                WRITE:   if (wr_end) state_q <= ARBIT;
                READ:    if (rd_end) state_q <= ARBIT;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign aref_en   = state_q == AREF;
    assign wr_en     = state_q == WRITE;
    assign rd_en     = state_q == READ;
    assign sdram_cke = 1'b1;
    // ARBIT (and any illegal encoding) drives NOP with all-ones ba/addr
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr} =
        state_q == IDLE  ? {init_cmd, init_ba, init_addr} :
        state_q == AREF  ? {aref_cmd, aref_ba, aref_addr} :
        state_q == WRITE ? {wr_cmd, wr_ba, wr_addr} :
        state_q == READ  ? {rd_cmd, rd_ba, rd_addr} :
                           {4'b0111, {BA_W{1'b1}}, {ADDR_W{1'b1}}};
    assign sdram_dq = (wr_sdram_en && state_q == WRITE) ? wr_data : {DQ_W{1'bz}};
endmodule
